e203_exu_oitf: RTL and testbench
================================

E203_EXU_OITF -- requirements
Module: e203_exu_oitf

Interface
REQ-001 SHALL have parameter OITF_DEPTH, default 2, number of outstanding long-pipe entries (power of 2, >=2).
REQ-002 SHALL have parameter ITAG_WIDTH, default 1, equal to log2(OITF_DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port dis_ena  input  1  allocate one entry; dispatch handshake of a long-pipe instruction.
REQ-006 SHALL have port dis_ready  output  1  table not full.
REQ-007 SHALL have port dis_ptr  output  ITAG_WIDTH  index of the next entry to allocate (instruction itag).
REQ-008 SHALL have port ret_ena  input  1  retire the oldest entry.
REQ-009 SHALL have port ret_ptr  output  ITAG_WIDTH  index of the oldest entry.
REQ-010 SHALL have ports ret_rdidx  output  5, ret_rdwen  output  1, ret_pc  output  32: contents of the oldest entry.
REQ-011 SHALL have ports disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen  input  1 each: operand/dest enables of the instruction at dispatch.
REQ-012 SHALL have ports disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx  input  5 each; disp_i_pc  input  32.
REQ-013 SHALL have ports oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd  output  1 each: hazard flags.
REQ-014 SHALL have port oitf_empty  output  1  no valid entry.

Function
REQ-015 SHALL hold per entry: vld, rdwen, rdidx[4:0], pc[31:0].
REQ-016 SHALL keep alc_ptr and ret_ptr (ITAG_WIDTH) each with a wrap flag toggled when the pointer wraps from OITF_DEPTH-1 to 0.
REQ-017 SHALL define empty = (alc_ptr==ret_ptr) & (flags equal); full = (alc_ptr==ret_ptr) & (flags differ).
REQ-018 SHALL drive dis_ready = ~full, oitf_empty = empty, dis_ptr = alc_ptr, ret_ptr = ret_ptr, combinationally.
REQ-019 SHALL, on dis_ena & ~full, write vld=1, rdwen, rdidx, pc into entry alc_ptr and advance alc_ptr by 1 modulo OITF_DEPTH.
REQ-020 SHALL ignore dis_ena while full: no state change.
REQ-021 SHALL, on ret_ena & ~empty, clear vld of entry ret_ptr and advance ret_ptr by 1 modulo OITF_DEPTH.
REQ-022 SHALL ignore ret_ena while empty: no state change.
REQ-023 SHALL process simultaneous allocate and retire in the same cycle independently; occupancy is unchanged. When full, a same-cycle dis_ena is still ignored even if ret_ena frees an entry.
REQ-024 SHALL drive ret_rdidx/ret_rdwen/ret_pc from entry ret_ptr combinationally. These outputs are don't-care when empty.
REQ-025 SHALL assert oitfrd_match_disprsN (N=1..3) when disp_i_rsNen=1 and some entry has vld=1, rdwen=1 and rdidx==disp_i_rsNidx; combinational, zero latency.
REQ-026 SHALL assert oitfrd_match_disprd when disp_i_rdwen=1 and some entry has vld=1, rdwen=1 and rdidx==disp_i_rdidx.
REQ-027 SHALL include an entry retiring in the current cycle in the match; SHALL exclude an entry being allocated in the current cycle; it becomes visible the next cycle.
REQ-028 SHALL not special-case register index 0 in matching.
REQ-029 SHALL keep latency 1 cycle from a dis_ena edge to oitf_empty=0, and from the ret_ena edge of the last entry to oitf_empty=1.

Reset
REQ-030 SHALL, on rising clk with rst_n=0, clear all vld, alc_ptr, ret_ptr and both wrap flags. Entry payload need not be reset.
REQ-031 SHALL, after reset, output oitf_empty=1, dis_ready=1, dis_ptr=0, ret_ptr=0 and all match flags 0.
REQ-032 SHALL give reset priority over a same-cycle dis_ena/ret_ena; mid-operation reset discards all entries.

Verification
REQ-033 SHALL cover fill: depth 2, allocate rdidx=5 pc=0x100, then rdidx=6 pc=0x104 -> dis_ptr 0,1,0; dis_ready=0 after the second allocation; a third dis_ena leaves state unchanged.
REQ-034 SHALL cover hazard: entry rdidx=5 rdwen=1, disp_i_rs2en=1 with rs2idx=5 -> oitfrd_match_disprs2=1; with rs2en=0 -> 0; entry rdwen=0 -> 0.
REQ-035 SHALL cover retire order: after REQ-033, ret_ena -> ret_rdidx=5 ret_pc=0x100, next cycle ret_rdidx=6 ret_pc=0x104; after the second retire oitf_empty=1.
REQ-036 SHALL cover simultaneous events: one entry valid, dis_ena and ret_ena in the same cycle -> occupancy stays 1, both pointers advance, oitf_empty stays 0; when full with both asserted -> only the retire takes effect.
REQ-037 SHALL cover wrap-around: 5 alloc/retire pairs -> pointers wrap, empty/full are correct at each step, no spurious match.
REQ-038 SHALL cover reset mid-operation: table full, rst_n=0 for one cycle -> oitf_empty=1, dis_ready=1, all match flags 0.

Source files
------------

// File: rtl/e203_exu_oitf.sv
// Outstanding instruction track FIFO: records long-pipe instructions from dispatch to
// write-back and flags register hazards against in-flight destinations.
module e203_exu_oitf #(
    parameter int OITF_DEPTH = 2,
    parameter int ITAG_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  dis_ena,
    output logic                  dis_ready,
    output logic [ITAG_WIDTH-1:0] dis_ptr,

    input  logic                  ret_ena,
    output logic [ITAG_WIDTH-1:0] ret_ptr,
    output logic [4:0]            ret_rdidx,
    output logic                  ret_rdwen,
    output logic [31:0]           ret_pc,

    input  logic                  disp_i_rs1en,
    input  logic                  disp_i_rs2en,
    input  logic                  disp_i_rs3en,
    input  logic                  disp_i_rdwen,
    input  logic [4:0]            disp_i_rs1idx,
    input  logic [4:0]            disp_i_rs2idx,
    input  logic [4:0]            disp_i_rs3idx,
    input  logic [4:0]            disp_i_rdidx,
    input  logic [31:0]           disp_i_pc,

    output logic                  oitfrd_match_disprs1,
    output logic                  oitfrd_match_disprs2,
    output logic                  oitfrd_match_disprs3,
    output logic                  oitfrd_match_disprd,
    output logic                  oitf_empty
);

    localparam logic [ITAG_WIDTH-1:0] LastPtr = ITAG_WIDTH'(OITF_DEPTH - 1);

    logic [OITF_DEPTH-1:0] vld_q, vld_d;
    logic [OITF_DEPTH-1:0] rdwen_q;
    logic [4:0]            rdidx_q [OITF_DEPTH];
    logic [31:0]           pc_q    [OITF_DEPTH];

    logic [ITAG_WIDTH-1:0] alc_ptr_q, alc_ptr_d;
    logic [ITAG_WIDTH-1:0] ret_ptr_q, ret_ptr_d;
    logic                  alc_flg_q, alc_flg_d;
    logic                  ret_flg_q, ret_flg_d;

    logic                  ptr_eq, empty, full;
    logic                  alc_fire, ret_fire;
    logic [OITF_DEPTH-1:0] ent_live;
    logic                  hit_rs1, hit_rs2, hit_rs3, hit_rd;

    // Wrap flags disambiguate empty from full when the pointers coincide.
    assign ptr_eq   = (alc_ptr_q == ret_ptr_q);
    assign empty    = ptr_eq & (alc_flg_q == ret_flg_q);
    assign full     = ptr_eq & (alc_flg_q != ret_flg_q);
    assign alc_fire = dis_ena & ~full;
    assign ret_fire = ret_ena & ~empty;

    assign dis_ready  = ~full;
    assign oitf_empty = empty;
    assign dis_ptr    = alc_ptr_q;
    assign ret_ptr    = ret_ptr_q;

    assign ret_rdidx = rdidx_q[ret_ptr_q];
    assign ret_rdwen = rdwen_q[ret_ptr_q];
    assign ret_pc    = pc_q[ret_ptr_q];

    always_comb begin
        vld_d     = vld_q;
        alc_ptr_d = alc_ptr_q;
        alc_flg_d = alc_flg_q;
        ret_ptr_d = ret_ptr_q;
        ret_flg_d = ret_flg_q;
        // Allocate and retire can never target the same slot in one cycle.
        if (alc_fire) begin
            vld_d[alc_ptr_q] = 1'b1;
            alc_ptr_d        = alc_ptr_q + ITAG_WIDTH'(1);
            if (alc_ptr_q == LastPtr) begin
                alc_flg_d = ~alc_flg_q;
            end
        end
        if (ret_fire) begin
            vld_d[ret_ptr_q] = 1'b0;
            ret_ptr_d        = ret_ptr_q + ITAG_WIDTH'(1);
            if (ret_ptr_q == LastPtr) begin
                ret_flg_d = ~ret_flg_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q     <= '0;
            alc_ptr_q <= '0;
            alc_flg_q <= 1'b0;
            ret_ptr_q <= '0;
            ret_flg_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            alc_ptr_q <= alc_ptr_d;
            alc_flg_q <= alc_flg_d;
            ret_ptr_q <= ret_ptr_d;
            ret_flg_q <= ret_flg_d;
        end
    end

    // Payload is qualified by vld, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alc_fire) begin
            rdwen_q[alc_ptr_q] <= disp_i_rdwen;
            rdidx_q[alc_ptr_q] <= disp_i_rdidx;
            pc_q[alc_ptr_q]    <= disp_i_pc;
        end
    end

    assign ent_live = vld_q & rdwen_q;

    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rs3 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (ent_live[i] && (rdidx_q[i] == disp_i_rs1idx)) hit_rs1 = 1'b1;
            if (ent_live[i] && (rdidx_q[i] == disp_i_rs2idx)) hit_rs2 = 1'b1;
            if (ent_live[i] && (rdidx_q[i] == disp_i_rs3idx)) hit_rs3 = 1'b1;
            if (ent_live[i] && (rdidx_q[i] == disp_i_rdidx))  hit_rd  = 1'b1;
        end
    end

    assign oitfrd_match_disprs1 = disp_i_rs1en & hit_rs1;
    assign oitfrd_match_disprs2 = disp_i_rs2en & hit_rs2;
    assign oitfrd_match_disprs3 = disp_i_rs3en & hit_rs3;
    assign oitfrd_match_disprd  = disp_i_rdwen & hit_rd;

endmodule

// File: tb/tb_e203_exu_oitf.sv
// Self-checking bench for e203_exu_oitf; a queue of in-flight entries models the table.
module tb_e203_exu_oitf;

    localparam int D = 2;
    localparam int W = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic dis_ena, dis_ready, ret_ena;
    logic [W-1:0] dis_ptr, ret_ptr;
    logic [4:0] ret_rdidx;
    logic ret_rdwen;
    logic [31:0] ret_pc;
    logic rs1en, rs2en, rs3en, rdwen;
    logic [4:0] rs1idx, rs2idx, rs3idx, rdidx;
    logic [31:0] pc;
    logic m1, m2, m3, mrd, empty;

    typedef struct packed {
        logic        rdwen;
        logic [4:0]  rdidx;
        logic [31:0] pc;
    } ent_t;

    ent_t sb[$];
    int   m_alc, m_ret;
    int   tests, fails;

    always #5 clk = ~clk;

    e203_exu_oitf #(.OITF_DEPTH(D), .ITAG_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
        .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx), .ret_rdwen(ret_rdwen),
        .ret_pc(ret_pc),
        .disp_i_rs1en(rs1en), .disp_i_rs2en(rs2en), .disp_i_rs3en(rs3en),
        .disp_i_rdwen(rdwen),
        .disp_i_rs1idx(rs1idx), .disp_i_rs2idx(rs2idx), .disp_i_rs3idx(rs3idx),
        .disp_i_rdidx(rdidx), .disp_i_pc(pc),
        .oitfrd_match_disprs1(m1), .oitfrd_match_disprs2(m2), .oitfrd_match_disprs3(m3),
        .oitfrd_match_disprd(mrd), .oitf_empty(empty)
    );

    function automatic logic mm(input logic en, input logic [4:0] idx);
        mm = 1'b0;
        if (en) foreach (sb[i]) if (sb[i].rdwen && sb[i].rdidx == idx) mm = 1'b1;
    endfunction

    // One clock of stimulus; the model mirrors what the table should accept.
    task automatic tick(input logic d, input logic r, input logic [4:0] idx,
                        input logic [31:0] p, input logic wen);
        logic acc_d, acc_r;
        dis_ena = d; ret_ena = r; rdidx = idx; pc = p; rdwen = wen;
        acc_d = d && (sb.size() != D);
        acc_r = r && (sb.size() != 0);
        @(posedge clk);
        if (acc_r) begin void'(sb.pop_front()); m_ret++; end
        if (acc_d) begin sb.push_back('{rdwen: wen, rdidx: idx, pc: p}); m_alc++; end
        @(negedge clk);
        dis_ena = 1'b0; ret_ena = 1'b0; rdwen = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete(); m_alc = 0; m_ret = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rs1en = 1; rs2en = 1; rs3en = 1; rdwen = 1;
        rs1idx = 0; rs2idx = 0; rs3idx = 0; rdidx = 0;
        #1;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (dis_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", dis_ready); end
        tests++; if (dis_ptr !== '0) begin fails++; $display("FAIL reset_dis_ptr got %0d want 0", dis_ptr); end
        tests++; if (ret_ptr !== '0) begin fails++; $display("FAIL reset_ret_ptr got %0d want 0", ret_ptr); end
        tests++; if ({m1, m2, m3, mrd} !== 4'b0) begin fails++; $display("FAIL reset_match got %b want 0000", {m1, m2, m3, mrd}); end
        rs1en = 0; rs2en = 0; rs3en = 0; rdwen = 0;
    endtask

    task automatic test_fill();
        tick(1, 0, 5'd5, 32'h100, 1);
        tests++; if (dis_ptr !== W'(1)) begin fails++; $display("FAIL fill_ptr1 got %0d want 1", dis_ptr); end
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL fill_empty got %b want 0", empty); end
        tests++; if (dis_ready !== 1'b1) begin fails++; $display("FAIL fill_ready1 got %b want 1", dis_ready); end
        tick(1, 0, 5'd6, 32'h104, 1);
        tests++; if (dis_ptr !== W'(0)) begin fails++; $display("FAIL fill_ptr2 got %0d want 0", dis_ptr); end
        tests++; if (dis_ready !== 1'b0) begin fails++; $display("FAIL fill_ready2 got %b want 0", dis_ready); end
        tick(1, 0, 5'd7, 32'h108, 1);
        tests++; if (dis_ptr !== W'(m_alc % D)) begin fails++; $display("FAIL fill_ovf_ptr got %0d want %0d", dis_ptr, m_alc % D); end
        tests++; if (dis_ready !== 1'b0) begin fails++; $display("FAIL fill_ovf_ready got %b want 0", dis_ready); end
        tests++; if (ret_pc !== sb[0].pc) begin fails++; $display("FAIL fill_ovf_head got %0h want %0h", ret_pc, sb[0].pc); end
        tests++; if (sb.size() != 2 || m_alc != 2) begin fails++; $display("FAIL fill_model got %0d want 2", sb.size()); end
    endtask

    task automatic test_hazard();
        rs2en = 1; rs2idx = 5; #1;
        tests++; if (m2 !== mm(1, 5)) begin fails++; $display("FAIL haz_rs2 got %b want %b", m2, mm(1, 5)); end
        rs2en = 0; #1;
        tests++; if (m2 !== 1'b0) begin fails++; $display("FAIL haz_rs2_off got %b want 0", m2); end
        rs1en = 1; rs1idx = 6; rs3en = 1; rs3idx = 7; rdwen = 1; rdidx = 6; #1;
        tests++; if (m1 !== mm(1, 6)) begin fails++; $display("FAIL haz_rs1 got %b want %b", m1, mm(1, 6)); end
        tests++; if (m3 !== mm(1, 7)) begin fails++; $display("FAIL haz_rs3 got %b want %b", m3, mm(1, 7)); end
        tests++; if (mrd !== mm(1, 6)) begin fails++; $display("FAIL haz_rd got %b want %b", mrd, mm(1, 6)); end
        rs1en = 0; rs3en = 0; rdwen = 0;
    endtask

    task automatic test_retire();
        ent_t exp;
        // A retiring entry still counts as a hazard in its retire cycle.
        ret_ena = 1; rs1en = 1; rs1idx = 5; #1;
        tests++; if (m1 !== 1'b1) begin fails++; $display("FAIL ret_live_match got %b want 1", m1); end
        rs1en = 0;
        for (int k = 0; k < 2; k++) begin
            exp = sb[0];
            tests++; if (ret_rdidx !== exp.rdidx || ret_pc !== exp.pc)
                begin fails++; $display("FAIL ret_order%0d got %0d/%0h want %0d/%0h", k, ret_rdidx, ret_pc, exp.rdidx, exp.pc); end
            tests++; if (ret_rdwen !== exp.rdwen) begin fails++; $display("FAIL ret_rdwen%0d got %b want %b", k, ret_rdwen, exp.rdwen); end
            tick(0, 1, 5'd0, 32'h0, 0);
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ret_empty got %b want 1", empty); end
        tests++; if (ret_ptr !== W'(m_ret % D)) begin fails++; $display("FAIL ret_ptr got %0d want %0d", ret_ptr, m_ret % D); end
    endtask

    task automatic test_alloc_visibility();
        tick(1, 0, 5'd5, 32'h200, 0);
        rs2en = 1; rs2idx = 5; #1;
        tests++; if (m2 !== 1'b0) begin fails++; $display("FAIL vis_nowen got %b want 0", m2); end
        rs2en = 0;
        // Entry being written this cycle must not match until the next cycle.
        dis_ena = 1; rdidx = 9; rdwen = 1; pc = 32'h204; rs1en = 1; rs1idx = 9; #1;
        tests++; if (m1 !== 1'b0) begin fails++; $display("FAIL vis_same_cycle got %b want 0", m1); end
        tick(1, 0, 5'd9, 32'h204, 1);
        tests++; if (m1 !== mm(1, 9)) begin fails++; $display("FAIL vis_next_cycle got %b want %b", m1, mm(1, 9)); end
        rdwen = 1; rdidx = 0; #1;
        tests++; if (mrd !== mm(1, 0)) begin fails++; $display("FAIL vis_rd_x0 got %b want %b", mrd, mm(1, 0)); end
        rs1en = 0; rdwen = 0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(1, 0, 5'd3, 32'h300, 1);
        tick(1, 1, 5'd4, 32'h304, 1);
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL sim_empty got %b want 0", empty); end
        tests++; if (dis_ready !== 1'b1 || sb.size() != 1) begin fails++; $display("FAIL sim_occ got %b want 1", dis_ready); end
        tests++; if (dis_ptr !== W'(m_alc % D) || ret_ptr !== W'(m_ret % D))
            begin fails++; $display("FAIL sim_ptrs got %0d/%0d want %0d/%0d", dis_ptr, ret_ptr, m_alc % D, m_ret % D); end
        tests++; if (ret_rdidx !== sb[0].rdidx) begin fails++; $display("FAIL sim_head got %0d want %0d", ret_rdidx, sb[0].rdidx); end
        tick(1, 0, 5'd8, 32'h308, 1);
        tests++; if (dis_ready !== 1'b0) begin fails++; $display("FAIL sim_full got %b want 0", dis_ready); end
        tick(1, 1, 5'd11, 32'h30c, 1);
        tests++; if (dis_ready !== 1'b1 || dis_ptr !== W'(m_alc % D))
            begin fails++; $display("FAIL sim_full_both got %b/%0d want 1/%0d", dis_ready, dis_ptr, m_alc % D); end
        rs1en = 1; rs1idx = 11; #1;
        tests++; if (m1 !== mm(1, 11)) begin fails++; $display("FAIL sim_dropped got %b want %b", m1, mm(1, 11)); end
        rs1en = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        rs1en = 1; rs1idx = 20;
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 5'(10 + i), 32'h400 + 32'(4 * i), 1);
            tests++; if (empty !== 1'b0 || dis_ready !== 1'b1 || dis_ptr !== W'(m_alc % D))
                begin fails++; $display("FAIL wrap_alc%0d got %b%b/%0d want 01/%0d", i, empty, dis_ready, dis_ptr, m_alc % D); end
            tests++; if (m1 !== mm(1, 20)) begin fails++; $display("FAIL wrap_match%0d got %b want 0", i, m1); end
            tests++; if (ret_rdidx !== sb[0].rdidx) begin fails++; $display("FAIL wrap_head%0d got %0d want %0d", i, ret_rdidx, sb[0].rdidx); end
            tick(0, 1, 5'd0, 32'h0, 0);
            tests++; if (empty !== 1'b1 || ret_ptr !== W'(m_ret % D))
                begin fails++; $display("FAIL wrap_ret%0d got %b/%0d want 1/%0d", i, empty, ret_ptr, m_ret % D); end
        end
        rs1en = 0;
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 5'd12, 32'h500, 1);
        tick(1, 0, 5'd13, 32'h504, 1);
        rst_n = 0; dis_ena = 1; ret_ena = 1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1; dis_ena = 0; ret_ena = 0;
        sb.delete(); m_alc = 0; m_ret = 0;
        rs1en = 1; rs1idx = 12; rs2en = 1; rs2idx = 13; rs3en = 1; rs3idx = 12;
        rdwen = 1; rdidx = 13; #1;
        tests++; if (empty !== 1'b1 || dis_ready !== 1'b1)
            begin fails++; $display("FAIL rmid_state got %b%b want 11", empty, dis_ready); end
        tests++; if (dis_ptr !== '0 || ret_ptr !== '0) begin fails++; $display("FAIL rmid_ptrs got %0d/%0d want 0/0", dis_ptr, ret_ptr); end
        tests++; if ({m1, m2, m3, mrd} !== 4'b0) begin fails++; $display("FAIL rmid_match got %b want 0000", {m1, m2, m3, mrd}); end
        rs1en = 0; rs2en = 0; rs3en = 0; rdwen = 0;
    endtask

    initial begin
        tests = 0; fails = 0; m_alc = 0; m_ret = 0;
        rst_n = 0; dis_ena = 0; ret_ena = 0;
        rs1en = 0; rs2en = 0; rs3en = 0; rdwen = 0;
        rs1idx = 0; rs2idx = 0; rs3idx = 0; rdidx = 0; pc = 0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_hazard();
        test_retire();
        test_alloc_visibility();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
